// File: rtl/aurora_tx_packer.sv
// aurora_tx_packer
//   Store-and-forward framer: packs the packetiser byte stream into 32-bit
//   MSB-first words, prepends a {sync, length} header and releases a packet
//   on the AXI-Stream side only once all of its words are stored.
//   Packets that do not fit, or that start while the link is down, are
//   dropped whole.
//
// Ports
//   i_clk, i_rst_n          Aurora user clock, async active-low reset
//   i_udp_data/vld/last     byte stream, no backpressure
//   i_udp_len               declared byte count, sampled on the first byte
//   i_channel_up            link status, checked at the first byte only
//   m_axis_*                AXI-Stream master, tkeep marks the valid bytes
//   o_drop_cnt              saturating count of dropped packets
//   o_len_err               one-cycle pulse on byte count != declared length
module aurora_tx_packer #(
  parameter int          P_FIFO_DEPTH = 1024,
  parameter logic [15:0] P_SYNC       = 16'hA55A
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_udp_data,
  input  logic        i_udp_vld,
  input  logic        i_udp_last,
  input  logic [15:0] i_udp_len,
  input  logic        i_channel_up,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [15:0] o_drop_cnt,
  output logic        o_len_err
);

  localparam int AW = $clog2(P_FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   RESV_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_PASS, S_DROP} state_t;

  // FIFO entry: {last, keep[3:0], data[31:0]}
  logic [36:0]   mem [P_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ, resv, pkt_cnt;

  state_t      state, state_n;
  logic [16:0] bcnt, bcnt_n, bcnt_inc;
  logic [31:0] acc, acc_n;
  logic [15:0] len_q, len_n;
  logic [AW:0] resv_n;

  // Write port A carries the header, port B a data word; both can fire in
  // the same cycle when a packet's first byte is also its last.
  logic        wa_en, wb_en;
  logic [36:0] wb_data;
  logic [1:0]  wr_n;
  logic        pkt_inc, pkt_dec, rd_en;
  logic        drop_inc, len_err_n;

  logic [1:0]  lane;
  logic [31:0] cur_word;
  logic [3:0]  cur_keep;
  logic [16:0] need;
  logic [17:0] free_w;
  logic        accept;
  logic [36:0] head;

  assign lane     = bcnt[1:0];
  assign cur_word = acc | ({i_udp_data, 24'h0} >> {lane, 3'b000});
  assign cur_keep = 4'hF << (2'd3 - lane);
  assign bcnt_inc = (bcnt == 17'h1FFFF) ? bcnt : bcnt + 17'd1;
  assign need     = (({1'b0, i_udp_len} + 17'd3) >> 2) + 17'd1;
  // Registered occupancy: a read in the same cycle only adds room.
  assign free_w   = 18'(P_FIFO_DEPTH) - 18'(occ) - 18'(resv);
  assign accept   = i_channel_up && (i_udp_len != 16'd0) && (free_w >= {1'b0, need});

  always_comb begin
    state_n   = state;
    bcnt_n    = bcnt;
    acc_n     = acc;
    len_n     = len_q;
    resv_n    = resv;
    wa_en     = 1'b0;
    wb_en     = 1'b0;
    wb_data   = '0;
    pkt_inc   = 1'b0;
    drop_inc  = 1'b0;
    len_err_n = 1'b0;
    case (state)
      S_IDLE: if (i_udp_vld) begin
        if (accept) begin
          wa_en = 1'b1;
          if (i_udp_last) begin
            wb_en     = 1'b1;
            wb_data   = {1'b1, 4'b1000, i_udp_data, 24'h0};
            pkt_inc   = 1'b1;
            len_err_n = (i_udp_len != 16'd1);
          end else begin
            state_n = S_PASS;
            bcnt_n  = 17'd1;
            acc_n   = {i_udp_data, 24'h0};
            len_n   = i_udp_len;
            resv_n  = (AW+1)'(need - 17'd1);
          end
        end else begin
          drop_inc = 1'b1;
          if (!i_udp_last) state_n = S_DROP;
        end
      end
      S_PASS: if (i_udp_vld) begin
        bcnt_n = bcnt_inc;
        acc_n  = (lane == 2'd3) ? 32'h0 : cur_word;
        if (i_udp_last) begin
          // resv never drops below 1 in PASS, so the final word always lands.
          wb_en     = 1'b1;
          wb_data   = {1'b1, cur_keep, cur_word};
          resv_n    = '0;
          pkt_inc   = 1'b1;
          len_err_n = (bcnt_inc != {1'b0, len_q});
          acc_n     = '0;
          bcnt_n    = '0;
          state_n   = S_IDLE;
        end else if (lane == 2'd3) begin
          wb_data = {1'b0, 4'hF, cur_word};
          if (resv > RESV_ONE) begin
            wb_en  = 1'b1;
            resv_n = resv - RESV_ONE;
          end else if (free_w != 18'd0) begin
            // over-length: spend unreserved space, keep the last slot held
            wb_en = 1'b1;
          end
        end
      end
      S_DROP: if (i_udp_vld && i_udp_last) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign head    = mem[rd_ptr];
  assign rd_en   = m_axis_tvalid && m_axis_tready;
  assign pkt_dec = rd_en && head[36];
  assign wr_n    = {1'b0, wa_en} + {1'b0, wb_en};

  // Only whole packets are visible downstream.
  assign m_axis_tvalid = (pkt_cnt != '0);
  assign m_axis_tdata  = m_axis_tvalid ? head[31:0]  : 32'h0;
  assign m_axis_tkeep  = m_axis_tvalid ? head[35:32] : 4'h0;
  assign m_axis_tlast  = m_axis_tvalid ? head[36]    : 1'b0;

  always_ff @(posedge i_clk) begin
    if (wa_en) mem[wr_ptr] <= {1'b0, 4'hF, P_SYNC, i_udp_len};
    if (wb_en) mem[wa_en ? wr_ptr + PTR_ONE : wr_ptr] <= wb_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      bcnt       <= '0;
      acc        <= '0;
      len_q      <= '0;
      resv       <= '0;
      occ        <= '0;
      pkt_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_drop_cnt <= '0;
      o_len_err  <= 1'b0;
    end else begin
      state     <= state_n;
      bcnt      <= bcnt_n;
      acc       <= acc_n;
      len_q     <= len_n;
      resv      <= resv_n;
      wr_ptr    <= wr_ptr + AW'(wr_n);
      rd_ptr    <= rd_ptr + AW'(rd_en);
      occ       <= occ + (AW+1)'(wr_n) - (AW+1)'(rd_en);
      pkt_cnt   <= pkt_cnt + (AW+1)'(pkt_inc) - (AW+1)'(pkt_dec);
      o_len_err <= len_err_n;
      if (drop_inc && o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end

endmodule
